// File: rtl/rps_match_driver.sv
// Initiator for the stone-paper-scissors game core: loads moves, runs the start
// handshake, samples the winner code and keeps a best-of-ROUNDS match score.
module rps_match_driver #(
    parameter int         ROUNDS      = 5,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         SAMPLE_DLY  = 2,
    parameter int         RELEASE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       vs_cpu,
    input  logic [1:0] p1_sel,
    input  logic [1:0] p2_sel,
    input  logic [1:0] result_i,
    output logic       start_o,
    output logic [1:0] p1_move_o,
    output logic [1:0] p2_move_o,
    output logic       round_done,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] round_cnt
);

    localparam logic [3:0] WIN_PTS      = 4'(ROUNDS / 2 + 1);
    localparam logic [3:0] MAX_ROUNDS   = 4'(ROUNDS);
    localparam logic [7:0] SAMPLE_LAST  = 8'(SAMPLE_DLY - 1);
    localparam logic [7:0] RELEASE_LAST = 8'(RELEASE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_lfsr;
    logic       r_go_q;
    logic [7:0] r_cnt;
    logic       r_start;
    logic [1:0] r_p1_move;
    logic [1:0] r_p2_move;
    logic       r_round_done;
    logic       r_match_done;
    logic [1:0] r_match_winner;
    logic [3:0] r_p1_score;
    logic [3:0] r_p2_score;
    logic [3:0] r_round_cnt;

    logic       w_go_rise;
    logic [1:0] w_cpu_move;
    logic       w_match_over;
    logic [1:0] w_winner;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign w_go_rise    = go & ~r_go_q;
    assign w_cpu_move   = 2'(r_lfsr % 8'd3);
    assign w_match_over = (r_p1_score == WIN_PTS) || (r_p2_score == WIN_PTS) ||
                          (r_round_cnt == MAX_ROUNDS);
    assign w_winner     = (r_p1_score > r_p2_score) ? 2'b01 :
                          (r_p2_score > r_p1_score) ? 2'b10 : 2'b00;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so the CPU move depends on timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_go_q <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_go_q <= go;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_start        <= 1'b0;
            r_p1_move      <= 2'b00;
            r_p2_move      <= 2'b00;
            r_round_done   <= 1'b0;
            r_match_done   <= 1'b0;
            r_match_winner <= 2'b00;
            r_p1_score     <= '0;
            r_p2_score     <= '0;
            r_round_cnt    <= '0;
        end else begin
            r_round_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go_rise) begin
                        r_p1_score     <= '0;
                        r_p2_score     <= '0;
                        r_round_cnt    <= '0;
                        r_match_done   <= 1'b0;
                        r_match_winner <= 2'b00;
                        r_state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_p1_move <= p1_sel;
                    r_p2_move <= vs_cpu ? w_cpu_move : p2_sel;
                    r_start   <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_START;
                end
                // Game core is in EVALUATE only on the last start cycle
                S_START: begin
                    if (r_cnt == SAMPLE_LAST) begin
                        r_start      <= 1'b0;
                        r_round_done <= 1'b1;
                        r_round_cnt  <= sat_inc(r_round_cnt);
                        case (result_i)
                            2'b01:   r_p1_score <= sat_inc(r_p1_score);
                            2'b10:   r_p2_score <= sat_inc(r_p2_score);
                            default: ;
                        endcase
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == RELEASE_LAST) begin
                        if (w_match_over) begin
                            r_match_done   <= 1'b1;
                            r_match_winner <= w_winner;
                            r_state        <= S_DONE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_o      = r_start;
    assign p1_move_o    = r_p1_move;
    assign p2_move_o    = r_p2_move;
    assign round_done   = r_round_done;
    assign match_done   = r_match_done;
    assign match_winner = r_match_winner;
    assign p1_score     = r_p1_score;
    assign p2_score     = r_p2_score;
    assign round_cnt    = r_round_cnt;

endmodule

// File: tb/tb_rps_match_driver.sv
// Scoreboard bench for rps_match_driver with a behavioural game core
// (IDLE -> EVALUATE -> RESULT) and a golden CPU-move LFSR.
module tb_rps_match_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       vs_cpu = 1'b0;
    logic [1:0] p1_sel = 2'b00;
    logic [1:0] p2_sel = 2'b00;
    logic [1:0] result_i;
    logic       start_o;
    logic [1:0] p1_move_o;
    logic [1:0] p2_move_o;
    logic       round_done;
    logic       match_done;
    logic [1:0] match_winner;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] round_cnt;

    rps_match_driver dut (
        .clk(clk), .rst_n(rst_n), .go(go), .vs_cpu(vs_cpu),
        .p1_sel(p1_sel), .p2_sel(p2_sel), .result_i(result_i),
        .start_o(start_o), .p1_move_o(p1_move_o), .p2_move_o(p2_move_o),
        .round_done(round_done), .match_done(match_done),
        .match_winner(match_winner), .p1_score(p1_score),
        .p2_score(p2_score), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] p1m;
        logic [1:0] p2m;
        logic [3:0] rc;
        logic [3:0] s1;
        logic [3:0] s2;
    } rexp_t;
    typedef struct {
        logic [1:0] w;
        logic [3:0] rc;
    } mexp_t;

    rexp_t round_q[$];
    mexp_t match_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    cpu_mode = 1'b0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural game core
    logic [1:0] g_st;
    logic [1:0] g_res;
    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b11 || b == 2'b11) return 2'b11;
        if (a == b) return 2'b00;
        if ((a == 2'b01 && b == 2'b00) || (a == 2'b10 && b == 2'b01) ||
            (a == 2'b00 && b == 2'b10)) return 2'b01;
        return 2'b10;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_st  <= 2'd0;
            g_res <= 2'b11;
        end else begin
            case (g_st)
                2'd0: if (start_o) begin
                    g_st  <= 2'd1;
                    g_res <= judge(p1_move_o, p2_move_o);
                end
                2'd1: g_st <= 2'd2;
                default: if (!start_o) g_st <= 2'd0;
            endcase
        end
    end
    assign result_i = (g_st == 2'd1) ? g_res : 2'b11;

    // Golden LFSR; m_prev is the value the DUT saw before the latest edge
    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // Monitor
    initial begin
        bit    s_prev;
        bit    md_prev;
        int    hi_cnt;
        int    n_starts;
        rexp_t r;
        mexp_t m;
        s_prev = 0; md_prev = 0; hi_cnt = 0; n_starts = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_prev = 0; md_prev = 0; hi_cnt = 0; n_starts = 0;
            end else begin
                if (start_o && !s_prev) begin
                    n_starts++;
                    hi_cnt = 0;
                    if (cpu_mode) begin
                        check("cpu_p2_move", {6'd0, p2_move_o}, m_prev % 8'd3);
                        check("cpu_not_11", {7'd0, p2_move_o == 2'b11}, 8'd0);
                    end
                end
                if (start_o) hi_cnt++;
                if (!start_o && s_prev) check("start_width", 8'(hi_cnt), 8'd2);
                if (round_done && !cpu_mode) begin
                    if (round_q.size() == 0) begin
                        check("unexpected_round", 8'd1, 8'd0);
                    end else begin
                        r = round_q.pop_front();
                        $display("[TB] round %0d: p1=%0d p2=%0d score %0d-%0d",
                                 round_cnt, p1_move_o, p2_move_o, p1_score, p2_score);
                        check("round_cnt", {4'd0, round_cnt}, {4'd0, r.rc});
                        check("p1_score", {4'd0, p1_score}, {4'd0, r.s1});
                        check("p2_score", {4'd0, p2_score}, {4'd0, r.s2});
                        check("p1_move", {6'd0, p1_move_o}, {6'd0, r.p1m});
                        check("p2_move", {6'd0, p2_move_o}, {6'd0, r.p2m});
                    end
                end
                if (match_done && !md_prev) begin
                    $display("[TB] match done: winner=%0d rounds=%0d", match_winner, round_cnt);
                    if (!cpu_mode) begin
                        if (match_q.size() == 0) begin
                            check("unexpected_match", 8'd1, 8'd0);
                        end else begin
                            m = match_q.pop_front();
                            check("match_winner", {6'd0, match_winner}, {6'd0, m.w});
                            check("match_rounds", {4'd0, round_cnt}, {4'd0, m.rc});
                            check("start_pulses", 8'(n_starts), {4'd0, m.rc});
                        end
                    end
                    n_starts = 0;
                end
                s_prev  = start_o;
                md_prev = match_done;
            end
        end
    end

    task automatic push_round(input logic [1:0] a, input logic [1:0] b,
                              input int rc, input int s1, input int s2);
        rexp_t r;
        r.p1m = a; r.p2m = b; r.rc = 4'(rc); r.s1 = 4'(s1); r.s2 = 4'(s2);
        round_q.push_back(r);
    endtask

    task automatic push_match(input logic [1:0] w, input int rc);
        mexp_t m;
        m.w = w; m.rc = 4'(rc);
        match_q.push_back(m);
    endtask

    // sel: 0 start_o high, 1 round_done, 2 match_done
    task automatic wait_for(input int sel, input string nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = start_o;
                1: hit = round_done;
                default: hit = match_done;
            endcase
        end
        if (!hit) check({"timeout_", nm}, 8'd0, 8'd1);
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic run_match(input logic [1:0] a, input logic [1:0] b, input bit cpu);
        p1_sel = a; p2_sel = b; vs_cpu = cpu; cpu_mode = cpu;
        pulse_go();
        wait_for(2, "match");
    endtask

    initial begin
        logic [1:0] mv[5];
        int starts_seen;

        // Reset state
        #12;
        check("rst_start", {7'd0, start_o}, 8'd0);
        check("rst_p1_score", {4'd0, p1_score}, 8'd0);
        check("rst_round_cnt", {4'd0, round_cnt}, 8'd0);
        check("rst_match_done", {7'd0, match_done}, 8'd0);
        @(negedge clk); rst_n = 1'b1;

        // Stone beats scissors three times: early win
        for (int i = 1; i <= 3; i++) push_round(2'b00, 2'b10, i, i, 0);
        push_match(2'b01, 3);
        run_match(2'b00, 2'b10, 1'b0);

        // Asynchronous reset in the middle of round 2
        push_round(2'b00, 2'b10, 1, 1, 0);
        p1_sel = 2'b00; p2_sel = 2'b10;
        pulse_go();
        wait_for(1, "round1");
        wait_for(0, "start2");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_start", {7'd0, start_o}, 8'd0);
        check("mid_rst_p1_score", {4'd0, p1_score}, 8'd0);
        check("mid_rst_round_cnt", {4'd0, round_cnt}, 8'd0);
        check("mid_rst_match_done", {7'd0, match_done}, 8'd0);
        round_q.delete();
        match_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scissors beats paper: P2 early win
        for (int i = 1; i <= 3; i++) push_round(2'b01, 2'b10, i, 0, i);
        push_match(2'b10, 3);
        run_match(2'b01, 2'b10, 1'b0);

        // Invalid P1 move every round: no score, full length, draw
        for (int i = 1; i <= 5; i++) push_round(2'b11, 2'b00, i, 0, 0);
        push_match(2'b00, 5);
        run_match(2'b11, 2'b00, 1'b0);

        // All ties
        for (int i = 1; i <= 5; i++) push_round(2'b01, 2'b01, i, 0, 0);
        push_match(2'b00, 5);
        run_match(2'b01, 2'b01, 1'b0);

        // Per-round P2 moves; p1_sel glitches during START must not leak in
        mv[0] = 2'b10; mv[1] = 2'b01; mv[2] = 2'b00; mv[3] = 2'b01; mv[4] = 2'b10;
        push_round(2'b00, 2'b10, 1, 1, 0);
        push_round(2'b00, 2'b01, 2, 1, 1);
        push_round(2'b00, 2'b00, 3, 1, 1);
        push_round(2'b00, 2'b01, 4, 1, 2);
        push_round(2'b00, 2'b10, 5, 2, 2);
        push_match(2'b00, 5);
        p1_sel = 2'b00; p2_sel = mv[0]; vs_cpu = 1'b0; cpu_mode = 1'b0;
        pulse_go();
        for (int r = 0; r < 5; r++) begin
            wait_for(0, "start_e");
            p1_sel = 2'b11;
            p2_sel = 2'b11;
            wait_for(1, "round_e");
            p1_sel = 2'b00;
            p2_sel = (r < 4) ? mv[r + 1] : 2'b00;
        end
        wait_for(2, "match_e");

        // go held high through the whole match and S_DONE
        for (int i = 1; i <= 3; i++) push_round(2'b01, 2'b00, i, i, 0);
        push_match(2'b01, 3);
        p1_sel = 2'b01; p2_sel = 2'b00;
        @(negedge clk); go = 1'b1;
        wait_for(2, "match_hold");
        starts_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (start_o) starts_seen++;
        end
        check("hold_no_restart", 8'(starts_seen), 8'd0);
        check("hold_match_done", {7'd0, match_done}, 8'd1);
        check("hold_p1_score", {4'd0, p1_score}, 8'd3);
        for (int i = 1; i <= 3; i++) push_round(2'b01, 2'b00, i, i, 0);
        push_match(2'b01, 3);
        go = 1'b0;
        @(negedge clk); go = 1'b1;
        @(posedge clk); #1;
        check("restart_match_done", {7'd0, match_done}, 8'd0);
        check("restart_p1_score", {4'd0, p1_score}, 8'd0);
        check("restart_round_cnt", {4'd0, round_cnt}, 8'd0);
        @(negedge clk); go = 1'b0;
        wait_for(2, "match_restart");

        // CPU opponent
        for (int k = 0; k < 5; k++) run_match(2'b00, 2'b00, 1'b1);
        cpu_mode = 1'b0;
        vs_cpu = 1'b0;
        repeat (3) @(negedge clk);

        check("round_q_empty", 8'(round_q.size()), 8'd0);
        check("match_q_empty", 8'(match_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
